// File: rtl/dma_reg_loader.sv
// Write/command side of an Am2940-style DMA address generator: decodes host
// instructions, owns the address/word/control state and steers the read mux.
module dma_reg_loader #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   instr,
    input  logic [W-1:0] data_in,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic         cnt_step,
    output logic [W-1:0] addr_cnt,
    output logic [W-1:0] word_cnt,
    output logic [2:0]   ctrl_reg,
    output logic [1:0]   seld,
    output logic         rd_valid,
    output logic         count_en,
    output logic         done
);

    typedef enum logic [2:0] {
        OP_WRCR   = 3'd0,
        OP_RDCR   = 3'd1,
        OP_RDWC   = 3'd2,
        OP_RDAC   = 3'd3,
        OP_REINIT = 3'd4,
        OP_LDAD   = 3'd5,
        OP_LDWC   = 3'd6,
        OP_ENCT   = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        RDOUT = 1'b1
    } state_e;

    state_e       state, state_nxt;
    logic [W-1:0] addr_reg;
    logic [W-1:0] word_reg;
    logic         accept;
    logic         is_read;
    logic         step_ok;
    logic [W-1:0] addr_stepped;
    logic [W-1:0] word_stepped;

    assign accept  = instr_valid & instr_ready;
    assign is_read = (instr == OP_RDCR) || (instr == OP_RDWC) || (instr == OP_RDAC);
    // An accepted instruction always wins over a same-cycle step.
    assign step_ok = cnt_step & count_en & ~done & ~accept;

    assign addr_stepped = ctrl_reg[2] ? (addr_cnt - W'(1)) : (addr_cnt + W'(1));
    assign word_stepped = word_cnt - W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_read) state_nxt = RDOUT;
            RDOUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state flop
    always_comb begin
        instr_ready = 1'b0;
        rd_valid    = 1'b0;
        case (state)
            IDLE:    instr_ready = 1'b1;
            RDOUT:   rd_valid    = 1'b1;
            default: instr_ready = 1'b0;
        endcase
    end

    // Register file and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            word_reg <= '0;
            addr_cnt <= '0;
            word_cnt <= '0;
            ctrl_reg <= '0;
            seld     <= '0;
            count_en <= 1'b0;
            done     <= 1'b0;
        end else if (accept) begin
            case (instr)
                OP_WRCR:   ctrl_reg <= data_in[2:0];
                OP_RDCR:   seld     <= 2'b10;
                OP_RDWC:   seld     <= 2'b01;
                OP_RDAC:   seld     <= 2'b00;
                OP_REINIT: begin
                    addr_cnt <= addr_reg;
                    word_cnt <= word_reg;
                    done     <= 1'b0;
                end
                OP_LDAD: begin
                    addr_reg <= data_in;
                    addr_cnt <= data_in;
                end
                OP_LDWC: begin
                    word_reg <= data_in;
                    word_cnt <= data_in;
                    done     <= 1'b0;
                end
                OP_ENCT: begin
                    count_en <= 1'b1;
                    done     <= (word_cnt == '0);
                end
                default: ;
            endcase
        end else if (step_ok) begin
            addr_cnt <= addr_stepped;
            word_cnt <= word_stepped;
            if (word_stepped == '0) begin
                done     <= 1'b1;
                count_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_reg_loader.sv
// Directed bench for dma_reg_loader: an abstract model checked every cycle,
// plus hand-computed literal expectations along the test sequence.
module tb_dma_reg_loader;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   instr;
    logic [W-1:0] data_in;
    logic         instr_valid;
    logic         instr_ready;
    logic         cnt_step;
    logic [W-1:0] addr_cnt;
    logic [W-1:0] word_cnt;
    logic [2:0]   ctrl_reg;
    logic [1:0]   seld;
    logic         rd_valid;
    logic         count_en;
    logic         done;

    int errors = 0;
    int checks = 0;

    dma_reg_loader #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .data_in     (data_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .cnt_step    (cnt_step),
        .addr_cnt    (addr_cnt),
        .word_cnt    (word_cnt),
        .ctrl_reg    (ctrl_reg),
        .seld        (seld),
        .rd_valid    (rd_valid),
        .count_en    (count_en),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: plain integers, rules applied per accepted instruction or step
    int m_addr, m_word, m_areg, m_wreg, m_ctrl, m_seld;
    bit m_en, m_done, m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr = 0; m_word = 0; m_areg = 0; m_wreg = 0;
            m_ctrl = 0; m_seld = 0; m_en = 0; m_done = 0; m_busy = 0;
        end else begin
            bit acc;
            acc = instr_valid && !m_busy;
            m_busy = 0;
            if (acc) begin
                case (int'(instr))
                    0: m_ctrl = int'(data_in) % 8;
                    1: begin m_seld = 2; m_busy = 1; end
                    2: begin m_seld = 1; m_busy = 1; end
                    3: begin m_seld = 0; m_busy = 1; end
                    4: begin m_addr = m_areg; m_word = m_wreg; m_done = 0; end
                    5: begin m_areg = int'(data_in); m_addr = m_areg; end
                    6: begin m_wreg = int'(data_in); m_word = m_wreg; m_done = 0; end
                    default: begin m_en = 1; m_done = (m_word == 0); end
                endcase
            end else if (cnt_step && m_en && !m_done) begin
                m_addr = (m_ctrl >= 4) ? (m_addr + 15) % 16 : (m_addr + 1) % 16;
                m_word = (m_word + 15) % 16;
                if (m_word == 0) begin
                    m_done = 1;
                    m_en = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m.addr_cnt",    int'(addr_cnt),    m_addr);
        chk("m.word_cnt",    int'(word_cnt),    m_word);
        chk("m.ctrl_reg",    int'(ctrl_reg),    m_ctrl);
        chk("m.seld",        int'(seld),        m_seld);
        chk("m.rd_valid",    int'(rd_valid),    int'(m_busy));
        chk("m.instr_ready", int'(instr_ready), int'(!m_busy));
        chk("m.count_en",    int'(count_en),    int'(m_en));
        chk("m.done",        int'(done),        int'(m_done));
    end

    // Drive one cycle of inputs, then move to just after the capturing edge
    task automatic cyc(input bit v, input int op, input int d, input bit s);
        instr_valid = v;
        instr       = 3'(op);
        data_in     = W'(d);
        cnt_step    = s;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        cnt_step    = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"},  int'(addr_cnt),    0);
        chk({tag, ".word"},  int'(word_cnt),    0);
        chk({tag, ".ctrl"},  int'(ctrl_reg),    0);
        chk({tag, ".seld"},  int'(seld),        0);
        chk({tag, ".rdv"},   int'(rd_valid),    0);
        chk({tag, ".en"},    int'(count_en),    0);
        chk({tag, ".done"},  int'(done),        0);
        chk({tag, ".ready"}, int'(instr_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr = '0; data_in = '0; instr_valid = 1'b0; cnt_step = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_reset("rst");
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Basic load / enable / count up to done
        cyc(1, 5, 3, 0);
        cyc(1, 6, 2, 0);
        cyc(1, 7, 0, 0);
        chk("t1.addr", int'(addr_cnt), 3);
        chk("t1.word", int'(word_cnt), 2);
        chk("t1.en",   int'(count_en), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t1.addr5", int'(addr_cnt), 5);
        chk("t1.word0", int'(word_cnt), 0);
        chk("t1.done",  int'(done),     1);
        chk("t1.en0",   int'(count_en), 0);
        cyc(0, 0, 0, 1);
        chk("t1.hold.addr", int'(addr_cnt), 5);
        chk("t1.hold.word", int'(word_cnt), 0);

        // Count down with wrap 0 -> F, then REINIT
        cyc(1, 0, 4, 0);
        cyc(1, 5, 0, 0);
        cyc(1, 6, 1, 0);
        cyc(1, 7, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t2.ctrl",  int'(ctrl_reg), 4);
        chk("t2.addrF", int'(addr_cnt), 15);
        chk("t2.done",  int'(done),     1);
        cyc(1, 4, 0, 0);
        chk("t2.ri.addr", int'(addr_cnt), 0);
        chk("t2.ri.word", int'(word_cnt), 1);
        chk("t2.ri.done", int'(done),     0);

        // Read timing: RDWC then a held instruction waits one cycle
        cyc(1, 2, 0, 0);
        chk("t3.seld",  int'(seld),        1);
        chk("t3.rdv",   int'(rd_valid),    1);
        chk("t3.rdy0",  int'(instr_ready), 0);
        cyc(1, 5, 6, 0);
        chk("t3.notacc", int'(addr_cnt),    0);
        chk("t3.rdy1",   int'(instr_ready), 1);
        chk("t3.rdv0",   int'(rd_valid),    0);
        chk("t3.seldh",  int'(seld),        1);
        cyc(1, 5, 6, 0);
        chk("t3.acc", int'(addr_cnt), 6);

        // Instruction beats step; then a down step
        cyc(1, 6, 5, 0);
        cyc(1, 7, 0, 0);
        chk("t4.en", int'(count_en), 1);
        cyc(1, 5, 9, 1);
        chk("t4.addr9", int'(addr_cnt), 9);
        chk("t4.word5", int'(word_cnt), 5);
        cyc(0, 0, 0, 1);
        chk("t4.addr8", int'(addr_cnt), 8);
        chk("t4.word4", int'(word_cnt), 4);

        // ENCT with word count zero
        cyc(1, 6, 0, 0);
        chk("t5.en_kept", int'(count_en), 1);
        chk("t5.done0",   int'(done),     0);
        cyc(1, 7, 0, 0);
        chk("t5.done1", int'(done), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t5.addr", int'(addr_cnt), 8);
        chk("t5.word", int'(word_cnt), 0);

        // Count up across F -> 0
        cyc(1, 0, 0, 0);
        cyc(1, 5, 15, 0);
        cyc(1, 6, 2, 0);
        cyc(1, 7, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t6.addr0", int'(addr_cnt), 0);
        chk("t6.word1", int'(word_cnt), 1);
        chk("t6.done",  int'(done),     0);

        // Asynchronous reset during RDOUT
        cyc(1, 5, 7, 0);
        cyc(1, 6, 3, 0);
        cyc(1, 1, 0, 0);
        chk("t7.rdv",  int'(rd_valid), 1);
        chk("t7.seld", int'(seld),     2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t7.async");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t7.ready", int'(instr_ready), 1);
        chk("t7.addr",  int'(addr_cnt),    0);
        cyc(1, 5, 10, 0);
        chk("t7.load", int'(addr_cnt), 10);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
